// File: rtl/axis_header_insert_param.sv
// axis_header_insert_param
//   Prepends a 0..DATA_BYTE_WD byte header to an AXI-Stream packet, shifting
//   the payload so header and payload bytes are packed tightly. Byte 0 is the
//   most significant byte, and keep is contiguous and MSB-aligned.
// Ports
//   clk, rst_n                         : clock, synchronous active-low reset
//   valid_in/data_in/keep_in/last_in   : payload slave (ready_in out)
//   valid_out/data_out/keep_out/last_out : master (ready_out in)
//   valid_insert/data_insert/byte_insert_cnt : header slave (ready_insert out)
module axis_header_insert_param #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL = '1;

  function automatic logic [DATA_BYTE_WD-1:0] keep_ones(input int unsigned k);
    return ~(KEEP_ALL >> k);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t                  state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  hcnt_q, hcnt_d;
  logic [DATA_WD-1:0]      carry_q, carry_d;
  logic                    vld_q, vld_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic                    last_q, last_d;
  logic [DATA_BYTE_WD-1:0] fkeep_q, fkeep_d;

  logic                    load_ok, ins_fire, pay_fire;
  int unsigned             h_u, p_u, hp_u;
  logic [DATA_WD-1:0]      packed_w, carry_top_w;

  assign load_ok      = !vld_q || ready_out;
  assign ready_insert = rst_n && (state_q == IDLE);
  assign ready_in     = rst_n && (state_q == RUN) && load_ok;
  assign ins_fire     = valid_insert && ready_insert;
  assign pay_fire     = valid_in && ready_in;

  assign valid_out = vld_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    carry_d = carry_q;
    vld_d   = vld_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    fkeep_d = fkeep_q;

    h_u = 32'(hcnt_q);
    p_u = 0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) p_u = p_u + 32'(keep_in[i]);
    hp_u = h_u + p_u;

    // Carry holds its valid bytes in the low H positions; shifting left by the
    // payload share moves them to the top and discards everything else.
    carry_top_w = carry_q << (8 * (DATA_BYTE_WD - h_u));
    packed_w    = carry_top_w | (data_in >> (8 * h_u));

    if (vld_q && ready_out) vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ins_fire) begin
          if (32'(byte_insert_cnt) > 32'(DATA_BYTE_WD)) hcnt_d = BYTE_CNT_WD'(DATA_BYTE_WD);
          else                                           hcnt_d = byte_insert_cnt;
          carry_d = data_insert;
          state_d = RUN;
        end
      end
      RUN: begin
        if (pay_fire) begin
          vld_d   = 1'b1;
          carry_d = data_in;
          if (!last_in) begin
            keep_d = KEEP_ALL;
            last_d = 1'b0;
          end else if (hp_u <= 32'(DATA_BYTE_WD)) begin
            keep_d  = keep_ones(hp_u);
            last_d  = 1'b1;
            state_d = IDLE;
          end else begin
            keep_d  = KEEP_ALL;
            last_d  = 1'b0;
            fkeep_d = keep_ones(hp_u - 32'(DATA_BYTE_WD));
            state_d = FLUSH;
          end
          data_d = packed_w & byte_mask(keep_d);
        end
      end
      FLUSH: begin
        // last_q distinguishes the pending full beat from the loaded tail beat.
        if (!last_q) begin
          if (load_ok) begin
            vld_d  = 1'b1;
            data_d = carry_top_w & byte_mask(fkeep_q);
            keep_d = fkeep_q;
            last_d = 1'b1;
          end
        end else if (vld_q && ready_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      carry_q <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      fkeep_q <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      fkeep_q <= fkeep_d;
    end
  end

endmodule

// File: tb/tb_axis_header_insert_param.sv
module tb_axis_header_insert_param;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [NB-1:0] keep_in = '0;
  logic          last_in = 1'b0;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [NB-1:0] keep_out;
  logic          last_out;
  logic          ready_out = 1'b1;
  logic          valid_insert = 1'b0;
  logic [DW-1:0] data_insert = '0;
  logic [CW-1:0] byte_insert_cnt = '0;
  logic          ready_insert;

  axis_header_insert_param #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mdl_q[$];
  beat_t         lit_q[$];
  logic [DW-1:0] pay_data[$];
  logic [NB-1:0] pay_keep[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            rdy_mode = 0;     // 0: always ready, 1: random, 2: rdy_force
  logic          rdy_force = 1'b1;

  function automatic beat_t mk(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected output: header bytes then payload bytes as one byte stream,
  // cut into NB-byte beats.
  task automatic build_model(input logic [DW-1:0] hdr, input logic [CW-1:0] cnt);
    logic [7:0] bq[$];
    int         h;
    int         p;
    beat_t      b;
    h = (int'(cnt) > NB) ? NB : int'(cnt);
    mdl_q.delete();
    for (int i = h - 1; i >= 0; i--) bq.push_back(hdr[8*i +: 8]);
    for (int j = 0; j < pay_data.size(); j++) begin
      p = NB;
      if (j == pay_data.size() - 1) begin
        p = 0;
        for (int k = 0; k < NB; k++) p += int'(pay_keep[j][k]);
      end
      for (int k = 0; k < p; k++) bq.push_back(pay_data[j][DW-1-8*k -: 8]);
    end
    while (bq.size() > 0) begin
      b = '0;
      for (int k = 0; k < NB && bq.size() > 0; k++) begin
        b.data[DW-1-8*k -: 8] = bq.pop_front();
        b.keep[NB-1-k] = 1'b1;
      end
      b.last = (bq.size() == 0);
      mdl_q.push_back(b);
    end
  endtask

  task automatic pin_model_and_queue(input string name);
    check({name, "_model_len"}, 64'(mdl_q.size()), 64'(lit_q.size()));
    for (int i = 0; i < lit_q.size() && i < mdl_q.size(); i++)
      check({name, "_model_beat"}, 64'(mdl_q[i]), 64'(lit_q[i]));
    foreach (lit_q[i]) exp_q.push_back(lit_q[i]);
    lit_q.delete();
  endtask

  task automatic queue_model();
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
  endtask

  task automatic send_packet(input logic [DW-1:0] hdr, input logic [CW-1:0] cnt, input int gap_max);
    int cyc;
    int n;
    n = pay_data.size();
    @(posedge clk); #1;
    valid_insert = 1'b1;
    data_insert = hdr;
    byte_insert_cnt = cnt;
    cyc = 0;
    @(negedge clk);
    while (!ready_insert && cyc < 400) begin @(negedge clk); cyc++; end
    check("hdr_handshake", 64'(ready_insert), 64'd1);
    @(posedge clk); #1;
    valid_insert = 1'b0;
    data_insert = $urandom;
    byte_insert_cnt = 3'($urandom_range(7, 0));
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      valid_in = 1'b1;
      data_in = pay_data[j];
      keep_in = pay_keep[j];
      last_in = (j == n - 1);
      cyc = 0;
      @(negedge clk);
      while (!ready_in && cyc < 400) begin @(negedge clk); cyc++; end
      check("pay_handshake", 64'(ready_in), 64'd1);
      @(posedge clk); #1;
      valid_in = 1'b0;
      data_in = $urandom;
      keep_in = 4'($urandom);
      last_in = 1'($urandom);
    end
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin @(negedge clk); cyc++; end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_req025_payload();
    pay_data.delete(); pay_keep.delete();
    pay_data.push_back(32'h01020304); pay_keep.push_back(4'hF);
    pay_data.push_back(32'h05060708); pay_keep.push_back(4'hF);
  endtask

  task automatic push_req025_lits();
    lit_q.push_back(mk(32'hCCDD0102, 4'hF, 1'b0));
    lit_q.push_back(mk(32'h03040506, 4'hF, 1'b0));
    lit_q.push_back(mk(32'h07080000, 4'hC, 1'b1));
  endtask

  // ready_out driver (lands at +2 so directed code writing rdy_force at +1 wins)
  initial forever begin
    @(posedge clk); #2;
    if (rdy_mode == 0)      ready_out = 1'b1;
    else if (rdy_mode == 1) ready_out = ($urandom_range(3, 0) != 0);
    else                    ready_out = rdy_force;
  end

  // Per-cycle output comparison against the expected-beat queue.
  initial begin
    beat_t cur;
    beat_t prev;
    beat_t e;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = mk(data_out, keep_out, last_out);
        vectors++;
        if ((ready_in && valid_out && !ready_out) || (ready_in && ready_insert)) begin
          miscompares++;
          $display("FAIL ready_rules: ready_in=%b ready_insert=%b valid_out=%b ready_out=%b",
                   ready_in, ready_insert, valid_out, ready_out);
        end
        if (prev_stall) begin
          vectors++;
          if (!valid_out || cur !== prev) begin
            miscompares++;
            $display("FAIL hold: got v=%b %h expected v=1 %h", valid_out, cur, prev);
          end
        end
        if (valid_out && ready_out) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL extra_beat: got %h expected no beat", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              miscompares++;
              $display("FAIL out_beat: got data=%h keep=%h last=%b expected data=%h keep=%h last=%b",
                       cur.data, cur.keep, cur.last, e.data, e.keep, e.last);
            end
          end
        end
        prev_stall = valid_out && !ready_out;
        prev = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] hdr;
    logic [CW-1:0] cnt;
    logic [NB-1:0] lk;
    int            n;
    int            p;

    // Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_in", 64'(ready_in), 64'd0);
    check("rst_ready_insert", 64'(ready_insert), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_outputs", {valid_out, data_out, keep_out, last_out}, '0);
    check("rst_ready_insert_released", 64'(ready_insert), 64'd1);

    // Header of 2 with a two-beat packet that needs a tail beat
    set_req025_payload();
    build_model(32'hAABBCCDD, 3'd2);
    push_req025_lits();
    pin_model_and_queue("h2_flush");
    send_packet(32'hAABBCCDD, 3'd2, 0);
    drain("h2_flush_drain");

    // Short last beat fits: no tail, ready_insert back next cycle
    pay_data.delete(); pay_keep.delete();
    pay_data.push_back(32'h11223344); pay_keep.push_back(4'hC);
    build_model(32'hAABBCCDD, 3'd2);
    lit_q.push_back(mk(32'hCCDD1122, 4'hF, 1'b1));
    pin_model_and_queue("h2_fit");
    send_packet(32'hAABBCCDD, 3'd2, 0);
    @(negedge clk);
    check("h2_fit_ready_insert", 64'(ready_insert), 64'd1);
    drain("h2_fit_drain");

    // No header: pass-through, one cycle latency
    pay_data.delete(); pay_keep.delete();
    pay_data.push_back(32'hDEADBEEF); pay_keep.push_back(4'hE);
    build_model(32'h12345678, 3'd0);
    lit_q.push_back(mk(32'hDEADBE00, 4'hE, 1'b1));
    pin_model_and_queue("h0");
    send_packet(32'h12345678, 3'd0, 0);
    @(negedge clk);
    check("h0_latency", {valid_out, data_out}, {1'b1, 32'hDEADBE00});
    drain("h0_drain");

    // Full-width header, one-byte payload
    pay_data.delete(); pay_keep.delete();
    pay_data.push_back(32'h11223344); pay_keep.push_back(4'h8);
    build_model(32'hAABBCCDD, 3'd4);
    lit_q.push_back(mk(32'hAABBCCDD, 4'hF, 1'b0));
    lit_q.push_back(mk(32'h11000000, 4'h8, 1'b1));
    pin_model_and_queue("h4");
    send_packet(32'hAABBCCDD, 3'd4, 0);
    drain("h4_drain");

    // Back-pressure: ready_out low for 5 cycles after the first output beat
    rdy_mode = 2;
    rdy_force = 1'b0;
    @(posedge clk);
    set_req025_payload();
    build_model(32'hAABBCCDD, 3'd2);
    push_req025_lits();
    pin_model_and_queue("stall");
    fork
      send_packet(32'hAABBCCDD, 3'd2, 0);
      begin
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!valid_out && cyc < 50) begin @(negedge clk); cyc++; end
        check("stall_first", {valid_out, data_out}, {1'b1, 32'hCCDD0102});
        repeat (5) begin
          @(negedge clk);
          check("stall_hold_data", 64'(data_out), 64'h00000000CCDD0102);
          check("stall_ready_in", 64'(ready_in), 64'd0);
        end
        @(posedge clk); #1;
        rdy_force = 1'b1;
      end
    join
    drain("stall_drain");
    rdy_mode = 0;

    // Reset mid-packet right after the second payload beat
    set_req025_payload();
    build_model(32'hAABBCCDD, 3'd2);
    queue_model();
    send_packet(32'hAABBCCDD, 3'd2, 0);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_ready_in", 64'(ready_in), 64'd0);
    check("midrst_ready_insert", 64'(ready_insert), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {valid_out, data_out, keep_out, last_out}, '0);
    check("midrst_idle", {ready_insert, ready_in}, 64'b10);
    set_req025_payload();
    build_model(32'hAABBCCDD, 3'd2);
    push_req025_lits();
    pin_model_and_queue("after_rst");
    send_packet(32'hAABBCCDD, 3'd2, 0);
    drain("after_rst_drain");

    // Randomized packets
    for (int t = 0; t < 150; t++) begin
      rdy_mode = (t % 3 == 0) ? 0 : 1;
      hdr = $urandom;
      cnt = 3'($urandom_range(7, 0));
      n = $urandom_range(4, 1);
      pay_data.delete(); pay_keep.delete();
      for (int j = 0; j < n; j++) begin
        pay_data.push_back($urandom);
        if (j == n - 1) begin
          p = $urandom_range(NB, 1);
          lk = 4'hF;
          lk = ~(lk >> p);
          pay_keep.push_back(lk);
        end else begin
          pay_keep.push_back(4'($urandom));
        end
      end
      build_model(hdr, cnt);
      queue_model();
      send_packet(hdr, cnt, 2);
    end
    drain("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_header_insert_param.md
AXIS_HEADER_INSERT_PARAM -- requirements
Module: axis_header_insert_param

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, meaning stream data width in bits; legal values are multiples of 8, from 8 to 512.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, meaning bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD+1), meaning header byte-count width (encodes 0..DATA_BYTE_WD).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; it is synchronous and active-low.
REQ-006 SHALL have ports valid_in (input, 1), data_in (input, DATA_WD), keep_in (input, DATA_BYTE_WD), last_in (input, 1) and ready_in (output, 1), forming the AXI-Stream payload slave.
REQ-007 SHALL have ports valid_out (output, 1), data_out (output, DATA_WD), keep_out (output, DATA_BYTE_WD), last_out (output, 1) and ready_out (input, 1), forming the AXI-Stream master.
REQ-008 SHALL have ports valid_insert (input, 1), data_insert (input, DATA_WD), byte_insert_cnt (input, BYTE_CNT_WD) and ready_insert (output, 1), forming the header slave.

Function
REQ-009 SHALL use big-endian byte order: byte 0 is data[DATA_WD-1 -: 8], and keep_in/keep_out are contiguous and MSB-aligned.
REQ-010 SHALL take the header as the low H bytes of data_insert, where H = min(byte_insert_cnt, DATA_BYTE_WD), captured on the header handshake.
REQ-011 SHALL emit, per packet, the H header bytes followed by all valid payload bytes, tightly packed, with invalid output bytes driven to 0.
REQ-012 SHALL implement an FSM with states IDLE, RUN and FLUSH; IDLE SHALL be the state after reset.
REQ-013 SHALL assert ready_insert only in IDLE and ready_in only in RUN, and in RUN only when the output register is empty or ready_out=1.
REQ-014 SHALL, on a header handshake in IDLE, move to RUN; no payload is accepted in the same cycle as the header handshake.
REQ-015 SHALL, on each payload handshake, load the output register in the next cycle with {carry (H bytes), upper N-H bytes of data_in}, where N = DATA_BYTE_WD; carry then becomes the low H bytes of data_in. The first beat of a packet uses the header bytes as carry.
REQ-016 SHALL treat non-last payload beats as full regardless of keep_in; on the last beat, P = popcount(keep_in), with 1 <= P <= N.
REQ-017 SHALL, on the last beat with H+P <= N, emit that beat with last_out=1 and keep_out = H+P ones MSB-aligned, then return to IDLE.
REQ-018 SHALL, on the last beat with H+P > N, emit that beat full with last_out=0 and move to FLUSH; FLUSH then emits the carry with keep_out = H+P-N ones MSB-aligned and last_out=1, and returns to IDLE on that beat's output handshake.
REQ-019 SHALL, when H=0, pass payload through unchanged with one cycle of latency.
REQ-020 SHALL hold data_out, keep_out and last_out stable while valid_out=1 and ready_out=0; no beat may be lost or duplicated.
REQ-021 SHALL sustain one beat per clock in RUN while ready_out=1, adding one extra beat only in the REQ-018 case.
REQ-022 SHALL ignore valid_insert outside IDLE and valid_in outside RUN.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, clear valid_out, data_out, keep_out, last_out, the carry and the latched H, and force the FSM to IDLE; this applies also when reset occurs mid-packet, and the partial packet is discarded.
REQ-024 SHALL drive ready_in=0 and ready_insert=0 while rst_n=0, and ready_insert=1 in the first cycle after reset is released.

Verification (DATA_WD=32)
REQ-025 SHALL verify: header 0xAABBCCDD with cnt=2; payload 0x01020304, then 0x05060708 (last, keep 1111); ready_out=1 -> outputs 0xCCDD0102/1111, 0x03040506/1111, then 0x07080000/1100 with last.
REQ-026 SHALL verify: cnt=2 with header 0xAABBCCDD; single payload beat 0x11223344 with keep 1100 and last -> one output beat 0xCCDD1122/1111 with last, no FLUSH, and ready_insert=1 in the next cycle.
REQ-027 SHALL verify: cnt=0; payload 0xDEADBEEF (last, keep 1110) -> output 0xDEADBE00/1110 with last, one cycle after the input handshake.
REQ-028 SHALL verify: cnt=4 with header 0xAABBCCDD; payload 0x11223344 with keep 1000 and last -> outputs 0xAABBCCDD/1111 (not last), then 0x11000000/1000 with last.
REQ-029 SHALL verify: the REQ-025 stimulus with ready_out held low for 5 cycles after the first output beat -> data_out stays 0xCCDD0102, ready_in=0 throughout, and the final sequence is identical.
REQ-030 SHALL verify: rst_n pulsed low for 1 cycle after the second payload beat -> all outputs are 0, the FSM is in IDLE, and a new packet then completes correctly.
